// File: rtl/ets_sweep_controller.sv
// Equivalent-time sweep sequencer: steps the ETS clock phase, runs the offset sampler at
// each position and queues the results in a fallthrough FIFO that the host drains.
module ets_sweep_controller #(
  parameter int RESULT_WIDTH  = 32,
  parameter int DEPTH         = 64,
  parameter int STEP_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [STEP_WIDTH-1:0]   step_count,
  output logic                    sampler_request_run,
  input  logic                    sampler_running,
  input  logic                    sampler_result_ready,
  input  logic [RESULT_WIDTH-1:0] sampler_result,
  output logic                    phase_step,
  input  logic                    phase_step_ack,
  output logic                    busy,
  output logic                    done,
  output logic [STEP_WIDTH-1:0]   position,
  input  logic                    rd_en,
  output logic                    rd_valid,
  output logic [RESULT_WIDTH-1:0] rd_data,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [AW:0]         PTR_ONE    = 1;
  localparam logic [STEP_WIDTH-1:0] STEP_ONE = 1;
  localparam logic [CW-1:0]       SET_ONE    = 1;
  localparam logic [CW-1:0]       SET_LOAD   = CW'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    IDLE, CHECK, REQUEST, WAIT_RESULT, STEP, WAIT_ACK, SETTLE, DRAIN
  } state_t;

  state_t                  state, state_n;
  logic [STEP_WIDTH-1:0]   count_q, count_n, pos_n;
  logic [CW-1:0]           settle_q, settle_n;
  logic                    done_n, push, pop, flush, full;
  logic [AW:0]             wr_ptr, rd_ptr;
  logic [RESULT_WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit, so level reaches DEPTH only when its MSB is set.
  assign level    = wr_ptr - rd_ptr;
  assign full     = level[AW];
  assign rd_valid = (level != '0);
  assign rd_data  = mem[rd_ptr[AW-1:0]];
  assign pop      = rd_en && rd_valid;

  always_comb begin
    state_n  = state;
    count_n  = count_q;
    pos_n    = position;
    settle_n = settle_q;
    done_n   = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
    // DRAIN is already the abort path; a second abort there must not strand the sampler.
    if (abort && state != IDLE && state != DRAIN) begin
      if ((state == REQUEST && sampler_running) ||
          (state == WAIT_RESULT && !sampler_result_ready)) begin
        state_n = DRAIN;
      end else begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end else begin
      case (state)
        IDLE: if (start) begin
          count_n = step_count;
          pos_n   = '0;
          flush   = 1'b1;
          if (step_count == '0) done_n = 1'b1;
          else                  state_n = CHECK;
        end
        CHECK:   if (!full) state_n = REQUEST;
        REQUEST: if (sampler_running) state_n = WAIT_RESULT;
        WAIT_RESULT: if (sampler_result_ready) begin
          push = 1'b1;
          if (position == count_q - STEP_ONE) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = STEP;
            pos_n   = position + STEP_ONE;
          end
        end
        STEP: state_n = WAIT_ACK;
        WAIT_ACK: if (phase_step_ack) begin
          state_n  = SETTLE;
          settle_n = SET_LOAD;
        end
        SETTLE: begin
          settle_n = settle_q - SET_ONE;
          if (settle_q == SET_ONE) state_n = CHECK;
        end
        DRAIN: if (sampler_result_ready) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so each one is a plain flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      count_q             <= '0;
      position            <= '0;
      settle_q            <= '0;
      sampler_request_run <= 1'b0;
      phase_step          <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      state               <= state_n;
      count_q             <= count_n;
      position            <= pos_n;
      settle_q            <= settle_n;
      sampler_request_run <= (state_n == REQUEST);
      phase_step          <= (state_n == STEP);
      busy                <= (state_n != IDLE);
      done                <= done_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= sampler_result;
  end

endmodule

// File: tb/tb_ets_sweep_controller.sv
// Bench for ets_sweep_controller: behavioural sampler/PLL responders plus a queue model
// of the result FIFO; each scenario task checks its own expectations.
module tb_ets_sweep_controller;
  localparam int RW = 32, DEPTH = 64, SW = 16, SETTLE = 16;
  // ack is taken on the next edge, SETTLE cycles pass, one CHECK cycle, then the
  // registered request appears: counted in clock edges from the ack being driven.
  localparam int GAP = SETTLE + 2;

  logic clk = 0, reset_n = 0, start = 0, abort = 0;
  logic [SW-1:0] step_count = '0;
  logic sampler_request_run, sampler_running = 0, sampler_result_ready = 0;
  logic [RW-1:0] sampler_result = '0;
  logic phase_step, phase_step_ack = 0, busy, done, rd_en = 0, rd_valid;
  logic [SW-1:0] position;
  logic [RW-1:0] rd_data;
  logic [$clog2(DEPTH):0] level;

  ets_sweep_controller #(.RESULT_WIDTH(RW), .DEPTH(DEPTH), .STEP_WIDTH(SW),
                         .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .step_count(step_count),
    .sampler_request_run(sampler_request_run), .sampler_running(sampler_running),
    .sampler_result_ready(sampler_result_ready), .sampler_result(sampler_result),
    .phase_step(phase_step), .phase_step_ack(phase_step_ack), .busy(busy), .done(done),
    .position(position), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .level(level));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int n_done = 0, n_ps = 0, n_ps_hi = 0, n_rr = 0, ack_cyc = 0;
  bit ack_pending = 0, ps_prev = 0, rr_prev = 0;
  int gaps[$];
  logic [RW-1:0] exp_q[$], smp_vals[$];
  bit smp_auto = 1;
  int smp_dmax = 2, ack_lo = 3, ack_hi = 3;

  always @(posedge clk) cyc = cyc + 1;

  // Event monitor: pulse counts and ack-to-request spacing.
  initial forever begin
    @(negedge clk);
    if (done) n_done++;
    if (phase_step) n_ps_hi++;
    if (phase_step && !ps_prev) n_ps++;
    if (sampler_request_run && !rr_prev) begin
      n_rr++;
      if (ack_pending) begin gaps.push_back(cyc - ack_cyc); ack_pending = 0; end
    end
    ps_prev = phase_step;
    rr_prev = sampler_request_run;
  end

  // PLL model: acknowledges each phase step after a delay.
  initial forever begin
    @(negedge clk);
    if (phase_step) begin
      repeat ($urandom_range(ack_hi, ack_lo)) @(negedge clk);
      phase_step_ack = 1; ack_cyc = cyc; ack_pending = 1;
      @(negedge clk);
      phase_step_ack = 0;
    end
  end

  // Sampler model: every delivered result is expected in the FIFO, in order.
  initial forever begin
    @(negedge clk);
    if (smp_auto && sampler_request_run && !sampler_running) begin
      repeat ($urandom_range(smp_dmax, 0)) @(negedge clk);
      sampler_running = 1;
      repeat ($urandom_range(smp_dmax, 0) + 1) @(negedge clk);
      sampler_running = 0;
      sampler_result_ready = 1;
      sampler_result = (smp_vals.size() != 0) ? smp_vals.pop_front() : $urandom;
      exp_q.push_back(sampler_result);
      @(negedge clk);
      sampler_result_ready = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic start_sweep(input int n);
    @(negedge clk);
    start = 1; step_count = SW'(n); exp_q.delete();
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int lim);
    int base = n_done;
    int i = 0;
    while (n_done == base && i < lim) begin @(negedge clk); i++; end
    total++;
    if (n_done == base) begin bad++; $display("FAIL done_timeout: got none want done"); end
  endtask

  task automatic wait_rr(input int lim);
    int i = 0;
    while (!sampler_request_run && i < lim) begin @(negedge clk); i++; end
    total++;
    if (!sampler_request_run) begin bad++; $display("FAIL rr_timeout: got 0 want 1"); end
  endtask

  task automatic drain(input int n, input string tag);
    int got = 0, guard = 0;
    while (got < n && guard < n * 40 + 100) begin
      @(negedge clk); guard++;
      rd_en = 0;
      if (rd_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL %s_extra: got %0d want empty", tag, rd_data);
        end else begin
          if (rd_data !== exp_q[0]) begin
            bad++; $display("FAIL %s_data: got %0d want %0d", tag, rd_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        got++; rd_en = 1;
      end
    end
    @(negedge clk); rd_en = 0;
    total++;
    if (got != n) begin bad++; $display("FAIL %s_count: got %0d want %0d", tag, got, n); end
  endtask

  task automatic test_reset();
    #1;
    total += 4;
    if (busy !== 0 || done !== 0) begin bad++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
    if (phase_step !== 0 || sampler_request_run !== 0) begin bad++; $display("FAIL rst_step_req: got %b%b want 00", phase_step, sampler_request_run); end
    if (position !== 0) begin bad++; $display("FAIL rst_position: got %0d want 0", position); end
    if (level !== 0 || rd_valid !== 0) begin bad++; $display("FAIL rst_level: got %0d/%b want 0/0", level, rd_valid); end
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_sweep(input int n, input int ps0, input int hi0, input int d0, input string tag);
    total += 6;
    if (n_ps - ps0 !== n - 1) begin bad++; $display("FAIL %s_steps: got %0d want %0d", tag, n_ps - ps0, n - 1); end
    if (n_ps_hi - hi0 !== n - 1) begin bad++; $display("FAIL %s_step_width: got %0d want %0d", tag, n_ps_hi - hi0, n - 1); end
    if (n_done - d0 !== 1) begin bad++; $display("FAIL %s_done_count: got %0d want 1", tag, n_done - d0); end
    if (position !== SW'(n - 1)) begin bad++; $display("FAIL %s_position: got %0d want %0d", tag, position, n - 1); end
    if (level !== n || busy !== 0) begin bad++; $display("FAIL %s_level: got %0d busy %b want %0d", tag, level, busy, n); end
    if (gaps.size() !== n - 1) begin bad++; $display("FAIL %s_gap_count: got %0d want %0d", tag, gaps.size(), n - 1); end
    foreach (gaps[i]) begin
      total++;
      if (gaps[i] !== GAP) begin bad++; $display("FAIL %s_settle_gap: got %0d want %0d", tag, gaps[i], GAP); end
    end
    drain(n, tag);
    total++;
    if (level !== 0) begin bad++; $display("FAIL %s_level_after: got %0d want 0", tag, level); end
  endtask

  task automatic test_basic_sweep();
    int ps0 = n_ps, hi0 = n_ps_hi, d0 = n_done;
    smp_vals = '{32'd10, 32'd20, 32'd30, 32'd40};
    ack_lo = 3; ack_hi = 3; gaps.delete();
    start_sweep(4);
    wait_done(2000);
    repeat (2) @(negedge clk);
    check_sweep(4, ps0, hi0, d0, "basic");
  endtask

  task automatic test_zero_count();
    int d0, rr0, ps0;
    start_sweep(1);
    wait_done(500);
    @(negedge clk);
    d0 = n_done; rr0 = n_rr; ps0 = n_ps;
    start_sweep(0);
    total += 3;
    if (done !== 1) begin bad++; $display("FAIL zero_done: got %b want 1", done); end
    if (busy !== 0) begin bad++; $display("FAIL zero_busy: got %b want 0", busy); end
    if (level !== 0) begin bad++; $display("FAIL zero_flush: got %0d want 0", level); end
    @(negedge clk);
    total++;
    if (done !== 0) begin bad++; $display("FAIL zero_done_width: got %b want 0", done); end
    repeat (5) @(negedge clk);
    total += 2;
    if (n_rr !== rr0 || n_ps !== ps0) begin bad++; $display("FAIL zero_activity: got %0d/%0d want 0/0", n_rr - rr0, n_ps - ps0); end
    if (n_done - d0 !== 1) begin bad++; $display("FAIL zero_done_count: got %0d want 1", n_done - d0); end
  endtask

  task automatic test_random_sweeps();
    smp_dmax = 3; ack_lo = 1; ack_hi = 6;
    for (int it = 0; it < 4; it++) begin
      int n = $urandom_range(8, 1);
      int ps0 = n_ps, hi0 = n_ps_hi, d0 = n_done;
      gaps.delete();
      start_sweep(n);
      wait_done(n * 80 + 100);
      repeat (2) @(negedge clk);
      check_sweep(n, ps0, hi0, d0, "rand");
    end
  endtask

  task automatic test_push_pop();
    logic [RW-1:0] a = $urandom, b = $urandom;
    smp_auto = 0; ack_lo = 2; ack_hi = 2;
    start_sweep(2);
    wait_rr(50);
    sampler_running = 1; @(negedge clk);
    sampler_running = 0; sampler_result_ready = 1; sampler_result = a; @(negedge clk);
    sampler_result_ready = 0;
    total++;
    if (level !== 1 || rd_data !== a) begin bad++; $display("FAIL pp_first: got %0d/%0d want 1/%0d", level, rd_data, a); end
    wait_rr(200);
    sampler_running = 1; @(negedge clk);
    sampler_running = 0; sampler_result_ready = 1; sampler_result = b; rd_en = 1; @(negedge clk);
    sampler_result_ready = 0; rd_en = 0;
    total += 2;
    if (level !== 1 || rd_data !== b) begin bad++; $display("FAIL pp_level_data: got %0d/%0d want 1/%0d", level, rd_data, b); end
    if (done !== 1) begin bad++; $display("FAIL pp_done: got %b want 1", done); end
    smp_auto = 1;
  endtask

  task automatic test_abort();
    int ps0, rr0;
    smp_auto = 0;
    start_sweep(3);
    wait_rr(50);
    sampler_running = 1; @(negedge clk);
    abort = 1; @(negedge clk);
    abort = 0;
    total++;
    if (sampler_request_run !== 0 || busy !== 1) begin bad++; $display("FAIL abort_drain: got req %b busy %b want 0/1", sampler_request_run, busy); end
    ps0 = n_ps;
    repeat (4) @(negedge clk);
    sampler_running = 0; sampler_result_ready = 1; sampler_result = 99; @(negedge clk);
    sampler_result_ready = 0;
    total += 2;
    if (done !== 1) begin bad++; $display("FAIL abort_done: got %b want 1", done); end
    if (busy !== 0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    @(negedge clk);
    total++;
    if (level !== 0 || rd_valid !== 0) begin bad++; $display("FAIL abort_discard: got %0d want 0", level); end
    repeat (20) @(negedge clk);
    total++;
    if (n_ps !== ps0) begin bad++; $display("FAIL abort_no_step: got %0d want 0", n_ps - ps0); end
    // abort coinciding with the result: abort wins, result dropped
    start_sweep(2);
    wait_rr(50);
    sampler_running = 1; @(negedge clk);
    sampler_running = 0; sampler_result_ready = 1; sampler_result = 77; abort = 1; @(negedge clk);
    sampler_result_ready = 0; abort = 0;
    total += 2;
    if (done !== 1 || busy !== 0) begin bad++; $display("FAIL prec_done: got %b busy %b want 1/0", done, busy); end
    if (level !== 0) begin bad++; $display("FAIL prec_discard: got %0d want 0", level); end
    rr0 = n_rr;
    repeat (10) @(negedge clk);
    total++;
    if (n_rr !== rr0) begin bad++; $display("FAIL prec_no_run: got %0d want 0", n_rr - rr0); end
    smp_auto = 1;
  endtask

  task automatic test_full_stall();
    int rr0 = n_rr, d0 = n_done, i = 0;
    smp_dmax = 2; ack_lo = 1; ack_hi = 3;
    start_sweep(70);
    while (level != DEPTH && i < 4000) begin @(negedge clk); i++; end
    repeat (60) @(negedge clk);
    total += 3;
    if (level !== DEPTH) begin bad++; $display("FAIL stall_level: got %0d want %0d", level, DEPTH); end
    if (busy !== 1 || sampler_request_run !== 0) begin bad++; $display("FAIL stall_state: got busy %b req %b want 1/0", busy, sampler_request_run); end
    if (n_rr - rr0 !== DEPTH) begin bad++; $display("FAIL stall_runs: got %0d want %0d", n_rr - rr0, DEPTH); end
    rd_en = 1;
    total++;
    if (rd_data !== exp_q[0]) begin bad++; $display("FAIL stall_pop: got %0d want %0d", rd_data, exp_q[0]); end
    void'(exp_q.pop_front());
    @(negedge clk);
    rd_en = 0;
    repeat (100) @(negedge clk);
    total += 2;
    if (level !== DEPTH) begin bad++; $display("FAIL stall_refill: got %0d want %0d", level, DEPTH); end
    if (n_rr - rr0 !== DEPTH + 1) begin bad++; $display("FAIL stall_one_run: got %0d want %0d", n_rr - rr0, DEPTH + 1); end
    drain(69, "stall");
    repeat (3) @(negedge clk);
    total += 2;
    if (n_done - d0 !== 1 || busy !== 0) begin bad++; $display("FAIL stall_done: got %0d busy %b want 1/0", n_done - d0, busy); end
    if (position !== 69) begin bad++; $display("FAIL stall_position: got %0d want 69", position); end
  endtask

  task automatic test_async_reset();
    int i = 0, ps0, hi0, d0;
    ack_lo = 2; ack_hi = 2; ack_pending = 0;
    start_sweep(3);
    while (!ack_pending && i < 300) begin @(negedge clk); i++; end
    repeat (4) @(negedge clk);
    total++;
    if (level !== 1 || busy !== 1) begin bad++; $display("FAIL ar_pre: got %0d busy %b want 1/1", level, busy); end
    #2 reset_n = 0;
    #1;
    total += 2;
    if (busy !== 0 || phase_step !== 0 || sampler_request_run !== 0) begin bad++; $display("FAIL ar_ctrl: got %b%b%b want 000", busy, phase_step, sampler_request_run); end
    if (level !== 0 || rd_valid !== 0) begin bad++; $display("FAIL ar_level: got %0d want 0", level); end
    repeat (2) @(negedge clk);
    reset_n = 1; ack_pending = 0; exp_q.delete();
    @(negedge clk);
    ps0 = n_ps; hi0 = n_ps_hi; d0 = n_done; gaps.delete();
    start_sweep(2);
    wait_done(400);
    repeat (2) @(negedge clk);
    check_sweep(2, ps0, hi0, d0, "ar_clean");
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_zero_count();
    test_random_sweeps();
    test_push_pop();
    test_abort();
    test_full_stall();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
